// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - reorder buffer retire end: in-order commit, CDB writeback, mispredict flush
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic              alloc_is_branch,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_mispredict,
    output logic              commit_valid,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_value,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              flush,
    output logic [TAG_W-1:0]  head_p,
    output logic [TAG_W-1:0]  tail_p,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   ONE_CNT  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] ONE_TAG  = TAG_W'(1);

    // Per-entry bookkeeping
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  ready_q;
    logic [DEPTH-1:0]  br_q;
    logic [DEPTH-1:0]  mp_q;
    logic [REG_W-1:0]  rd_q  [DEPTH];
    logic [DATA_W-1:0] val_q [DEPTH];

    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;

    logic head_live;
    logic flush_now;
    logic retire;
    logic alloc_fire;

    // Head decisions are taken from registered state only, so a result
    // arriving on the CDB this cycle can never retire in the same cycle.
    always_comb begin
        head_live  = busy_q[head_q] && ready_q[head_q];
        flush_now  = head_live && br_q[head_q] && mp_q[head_q];
        retire     = head_live && !flush_now;
        alloc_fire = alloc_valid && alloc_ready;
    end

    assign alloc_ready = (count_q < FULL_CNT) && !flush_now;
    assign alloc_tag   = tail_q;
    assign head_p      = head_q;
    assign tail_p      = tail_q;
    assign count       = count_q;

    // Entry state: CDB writeback, retire clear, then allocation; a flush
    // discards everything including any CDB write or alloc this cycle.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            ready_q <= '0;
            br_q    <= '0;
            mp_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]  <= '0;
                val_q[i] <= '0;
            end
        end else if (flush_now) begin
            busy_q  <= '0;
            ready_q <= '0;
        end else begin
            if (cdb_valid && busy_q[cdb_tag]) begin
                ready_q[cdb_tag] <= 1'b1;
                val_q[cdb_tag]   <= cdb_value;
                mp_q[cdb_tag]    <= cdb_mispredict;
            end
            if (retire) begin
                busy_q[head_q] <= 1'b0;
            end
            if (alloc_fire) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                br_q[tail_q]    <= alloc_is_branch;
                mp_q[tail_q]    <= 1'b0;
                rd_q[tail_q]    <= alloc_rd;
            end
        end
    end

    // Head/tail pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (flush_now) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (retire) begin
                head_q <= head_q + ONE_TAG;
            end
            if (alloc_fire) begin
                tail_q <= tail_q + ONE_TAG;
            end
        end
    end

    // Occupancy: an alloc and a retire in the same cycle cancel out.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (flush_now) begin
            count_q <= '0;
        end else begin
            case ({alloc_fire, retire})
                2'b10:   count_q <= count_q + ONE_CNT;
                2'b01:   count_q <= count_q - ONE_CNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered commit and flush pulses; commit payload holds between pulses.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_tag   <= '0;
            flush        <= 1'b0;
        end else begin
            commit_valid <= retire && !br_q[head_q];
            flush        <= flush_now;
            if (retire && !br_q[head_q]) begin
                commit_rd    <= rd_q[head_q];
                commit_value <= val_q[head_q];
                commit_tag   <= head_q;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - randomized and directed bench for rob_commit against an in-order queue model
module tb_rob_commit;

    logic        clk1;
    logic        rst;
    logic        alloc_valid;
    logic [3:0]  alloc_rd;
    logic        alloc_is_branch;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_value;
    logic        cdb_mispredict;
    logic        commit_valid;
    logic [3:0]  commit_rd;
    logic [15:0] commit_value;
    logic [2:0]  commit_tag;
    logic        flush;
    logic [2:0]  head_p;
    logic [2:0]  tail_p;
    logic [3:0]  count;

    rob_commit #(.DEPTH(8), .TAG_W(3), .DATA_W(16), .REG_W(4)) dut (
        .clk1(clk1), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_mispredict(cdb_mispredict),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_tag(commit_tag), .flush(flush),
        .head_p(head_p), .tail_p(tail_p), .count(count)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: in-flight instructions oldest first; head tag tracked separately.
    typedef struct {
        logic [3:0]  rd;
        bit          br;
        bit          rdy;
        bit          mp;
        logic [15:0] val;
    } ent_t;

    ent_t        q[$];
    int          mh = 0;
    bit          e_cv = 0;
    bit          e_fl = 0;
    logic [3:0]  e_rd = '0;
    logic [15:0] e_val = '0;
    logic [2:0]  e_tag = '0;

    function automatic bit model_flush_now();
        return (q.size() > 0) && q[0].rdy && q[0].br && q[0].mp;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        int   n;
        bit   fn;
        bit   acc;
        bit   ret;
        int   idx;
        ent_t h;
        ent_t ne;
        if (rst) begin
            q.delete();
            mh = 0; e_cv = 0; e_fl = 0; e_rd = '0; e_val = '0; e_tag = '0;
            return;
        end
        n   = q.size();
        fn  = model_flush_now();
        acc = alloc_valid && (n < 8) && !fn;
        e_cv = 0;
        e_fl = 0;
        if (fn) begin
            q.delete();
            mh   = 0;
            e_fl = 1;
            return;
        end
        ret = (n > 0) && q[0].rdy;
        if (n > 0) h = q[0];
        if (cdb_valid) begin
            idx = (int'(cdb_tag) - mh + 8) % 8;
            if (idx < n) begin
                q[idx].val = cdb_value;
                q[idx].mp  = cdb_mispredict;
                q[idx].rdy = 1;
            end
        end
        if (ret) begin
            if (!h.br) begin
                e_cv  = 1;
                e_rd  = h.rd;
                e_val = h.val;
                e_tag = 3'(mh);
            end
            void'(q.pop_front());
            mh = (mh + 1) % 8;
        end
        if (acc) begin
            ne.rd = alloc_rd; ne.br = alloc_is_branch; ne.rdy = 0; ne.mp = 0; ne.val = '0;
            q.push_back(ne);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk1) begin
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("head_p", 32'(head_p), 32'(mh));
        chk("tail_p", 32'(tail_p), 32'((mh + n) % 8));
        chk("alloc_tag", 32'(alloc_tag), 32'((mh + n) % 8));
        chk("alloc_ready", 32'(alloc_ready), 32'((n < 8) && !model_flush_now()));
        chk("commit_valid", 32'(commit_valid), 32'(e_cv));
        chk("flush", 32'(flush), 32'(e_fl));
        if (e_cv) begin
            chk("commit_rd", 32'(commit_rd), 32'(e_rd));
            chk("commit_value", 32'(commit_value), 32'(e_val));
            chk("commit_tag", 32'(commit_tag), 32'(e_tag));
        end
    end

    task automatic drive(input bit av, input logic [3:0] rd, input bit br,
                         input bit cv, input logic [2:0] ct, input logic [15:0] cval, input bit cmp);
        alloc_valid = av; alloc_rd = rd; alloc_is_branch = br;
        cdb_valid = cv; cdb_tag = ct; cdb_value = cval; cdb_mispredict = cmp;
        @(posedge clk1);
        model_update();
        #1;
    endtask

    task automatic idle();
        drive(0, 4'd0, 0, 0, 3'd0, 16'd0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_update();
        idle();
        rst = 1'b0;
    endtask

    initial begin
        bit          av, br, cv, cmp;
        logic [3:0]  rd;
        logic [2:0]  ct;
        logic [15:0] cval;
        int          n;

        rst = 1'b1;
        alloc_valid = 0; alloc_rd = '0; alloc_is_branch = 0;
        cdb_valid = 0; cdb_tag = '0; cdb_value = '0; cdb_mispredict = 0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_commit_rd", 32'(commit_rd), 32'd0);
        chk("rst_commit_value", 32'(commit_value), 32'd0);
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        idle();
        idle();
        rst = 1'b0;

        // Reset mid-stream with five entries busy
        for (int i = 0; i < 5; i++) drive(1, 4'(i + 1), 0, 0, 3'd0, 16'd0, 0);
        chk("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_head", 32'(head_p), 32'd0);
        chk("mid_rst_tail", 32'(tail_p), 32'd0);
        chk("mid_rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("mid_rst_flush", 32'(flush), 32'd0);
        chk("mid_rst_alloc_ready", 32'(alloc_ready), 32'd1);
        model_update();
        idle();
        rst = 1'b0;

        // In-order retire with out-of-order results
        drive(1, 4'd1, 0, 0, 3'd0, 16'd0, 0);
        drive(1, 4'd2, 0, 0, 3'd0, 16'd0, 0);
        drive(1, 4'd3, 0, 0, 3'd0, 16'd0, 0);
        drive(0, 4'd0, 0, 1, 3'd2, 16'h0033, 0);
        drive(0, 4'd0, 0, 1, 3'd0, 16'h0011, 0);
        chk("order_no_early", 32'(commit_valid), 32'd0);
        drive(0, 4'd0, 0, 1, 3'd1, 16'h0022, 0);
        chk("order_c0_valid", 32'(commit_valid), 32'd1);
        chk("order_c0_rd", 32'(commit_rd), 32'd1);
        chk("order_c0_val", 32'(commit_value), 32'h0011);
        idle();
        chk("order_c1_rd", 32'(commit_rd), 32'd2);
        chk("order_c1_val", 32'(commit_value), 32'h0022);
        idle();
        chk("order_c2_rd", 32'(commit_rd), 32'd3);
        chk("order_c2_val", 32'(commit_value), 32'h0033);
        chk("order_c2_tag", 32'(commit_tag), 32'd2);
        idle();
        do_reset();

        // Full buffer and wrap
        for (int i = 0; i < 8; i++) drive(1, 4'(i), 0, 0, 3'd0, 16'd0, 0);
        chk("full_count", 32'(count), 32'd8);
        chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
        drive(0, 4'd0, 0, 1, 3'd0, 16'h1234, 0);
        drive(1, 4'hA, 0, 0, 3'd0, 16'd0, 0);
        chk("full_refused_count", 32'(count), 32'd7);
        chk("full_commit_valid", 32'(commit_valid), 32'd1);
        chk("full_commit_val", 32'(commit_value), 32'h1234);
        chk("full_alloc_tag", 32'(alloc_tag), 32'd0);
        drive(1, 4'hB, 0, 0, 3'd0, 16'd0, 0);
        chk("wrap_tail", 32'(tail_p), 32'd1);
        chk("wrap_count", 32'(count), 32'd8);
        do_reset();

        // Simultaneous alloc and commit at count 4
        for (int i = 0; i < 4; i++) drive(1, 4'(i + 4), 0, 0, 3'd0, 16'd0, 0);
        for (int i = 1; i <= 4; i++) drive(0, 4'd0, 0, 1, 3'(i % 4), 16'(i * 16'h0101), 0);
        chk("sim_pre_count", 32'(count), 32'd4);
        drive(1, 4'd9, 0, 0, 3'd0, 16'd0, 0);
        chk("sim_count", 32'(count), 32'd4);
        chk("sim_head", 32'(head_p), 32'd1);
        chk("sim_tail", 32'(tail_p), 32'd5);
        drive(1, 4'd10, 0, 0, 3'd0, 16'd0, 0);
        chk("sim2_head", 32'(head_p), 32'd2);
        chk("sim2_tail", 32'(tail_p), 32'd6);
        chk("sim2_count", 32'(count), 32'd4);
        do_reset();

        // Mispredicted branch flushes younger work
        drive(1, 4'd0, 1, 0, 3'd0, 16'd0, 0);
        drive(1, 4'd5, 0, 0, 3'd0, 16'd0, 0);
        drive(0, 4'd0, 0, 1, 3'd1, 16'h00AA, 0);
        drive(0, 4'd0, 0, 1, 3'd0, 16'h0000, 1);
        drive(1, 4'd9, 0, 0, 3'd0, 16'd0, 0);
        chk("misp_flush", 32'(flush), 32'd1);
        chk("misp_commit_valid", 32'(commit_valid), 32'd0);
        chk("misp_count", 32'(count), 32'd0);
        chk("misp_alloc_tag", 32'(alloc_tag), 32'd0);
        drive(1, 4'd7, 0, 0, 3'd0, 16'd0, 0);
        chk("misp_flush_end", 32'(flush), 32'd0);
        chk("misp_new_tail", 32'(tail_p), 32'd1);
        do_reset();

        // Correct branch, then a stray CDB write to an idle entry
        drive(1, 4'd0, 1, 0, 3'd0, 16'd0, 0);
        drive(0, 4'd0, 0, 1, 3'd0, 16'd0, 0);
        drive(0, 4'd0, 0, 1, 3'd6, 16'hBEEF, 0);
        chk("br_ok_commit_valid", 32'(commit_valid), 32'd0);
        chk("br_ok_head", 32'(head_p), 32'd1);
        chk("br_ok_count", 32'(count), 32'd0);
        for (int i = 0; i < 6; i++) drive(1, 4'(i), 0, 0, 3'd0, 16'd0, 0);
        idle();
        idle();
        chk("stray_count", 32'(count), 32'd6);
        do_reset();

        // Randomized traffic with occasional reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                n    = q.size();
                av   = ($urandom_range(0, 9) < 6);
                rd   = 4'($urandom);
                br   = ($urandom_range(0, 3) == 0);
                cv   = ($urandom_range(0, 9) < 6);
                cval = 16'($urandom);
                cmp  = ($urandom_range(0, 5) == 0);
                if (n > 0 && $urandom_range(0, 4) != 0)
                    ct = 3'((mh + $urandom_range(0, n - 1)) % 8);
                else
                    ct = 3'($urandom);
                drive(av, rd, br, cv, ct, cval, cmp);
            end
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer with in-order commit for the Tomasulo core; the retiring end of the ROB whose tail the issue stage allocates. The issue stage claims an entry at `tail_p` and receives its tag. The common data bus (CDB) writes results back by tag. This block retires entries strictly from `head_p` in order, drives architectural register-bank writes and flushes the whole buffer on a mispredicted branch.

## Interface
- `DEPTH`, 8, number of ROB entries (power of two)
- `TAG_W`, 3, entry index width, log2(DEPTH)
- `DATA_W`, 16, result width
- `REG_W`, 4, architectural register index width

- `clk1`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alloc_valid`  in  1  issue stage requests an entry this cycle
- `alloc_rd`  in  REG_W  destination register of the issuing instruction
- `alloc_is_branch`  in  1  issuing instruction is a branch (no register write)
- `alloc_ready`  out  1  an entry is free and no flush is pending; combinational
- `alloc_tag`  out  TAG_W  tag granted on an accepted alloc; equals `tail_p`
- `cdb_valid`  in  1  result broadcast present
- `cdb_tag`  in  TAG_W  ROB entry the result belongs to
- `cdb_value`  in  DATA_W  result value
- `cdb_mispredict`  in  1  branch resolved as mispredicted; meaningful only for branch entries
- `commit_valid`  out  1  one-cycle pulse: register-bank write this cycle
- `commit_rd`  out  REG_W  register to write
- `commit_value`  out  DATA_W  value to write
- `commit_tag`  out  TAG_W  tag of the retired entry
- `flush`  out  1  one-cycle pulse: mispredict, all younger work discarded
- `head_p`  out  TAG_W  oldest entry
- `tail_p`  out  TAG_W  next entry to allocate
- `count`  out  TAG_W+1  occupied entries, 0..DEPTH

## Operation
- Per-entry state: `busy`, `ready`, `is_branch`, `mispredict`, `rd`, `value`.
- **Alloc.** An alloc is accepted when `alloc_valid && alloc_ready`.
  - On acceptance, entry[tail_p] gets busy=1, ready=0, and `rd`/`is_branch` are latched.
  - `tail_p` advances by 1 and wraps DEPTH-1→0.
- `alloc_ready = (count < DEPTH) && !flush_now`.
  - `flush_now` means the head entry is busy, ready, a branch and mispredicted.
- **CDB.** On `cdb_valid` with entry[cdb_tag].busy=1, latch the value and mispredict bit and set ready=1.
  - A CDB write to a non-busy entry is ignored.
- **Commit.** This is evaluated on registered state, so a CDB result is never retired in the cycle it arrives. If the head entry is busy and ready:
  - Non-branch: register `commit_valid`=1 with rd, value and tag. Clear busy and advance `head_p` (wrap).
  - Branch, not mispredicted: clear busy and advance `head_p`. `commit_valid` stays 0.
  - Branch, mispredicted: register `flush`=1. Clear every busy bit and set head_p=tail_p=0 and count=0. An alloc in that cycle is refused, since `alloc_ready`=0. A CDB write in that cycle is discarded.
- At most one retire per cycle.
- `count` update per cycle: +1 for an accepted alloc, −1 for a retire, net 0 when both happen.
  - A full buffer that retires this cycle accepts no alloc until the next cycle, because `alloc_ready` is derived from the registered count.
- Empty (count=0): no commit. head_p equals tail_p.
- Full (count=DEPTH): head_p also equals tail_p. `count` disambiguates full from empty.

## Timing
- Reset (async, immediate): all entries not busy; head_p=tail_p=0, count=0.
  - commit_valid=0, commit_rd=0, commit_value=0, commit_tag=0, flush=0.
  - alloc_ready=1, alloc_tag=0.
- Reset mid-operation discards all entries, and any pending commit or flush pulse drops the same cycle.
- Alloc at edge N: entry valid from N. CDB for that tag at edge M≥N+1.
- Earliest commit is at edge M+1 if the entry is at the head. `commit_valid` is high during cycle M+1→M+2 only.
- Flush follows the same M+1 timing and lasts exactly one cycle. New allocs are accepted from the following cycle at tag 0.
- Sustained throughput: one alloc and one commit per cycle.

## Test plan
- **Reset.** Assert rst mid-stream with 5 entries busy → immediately count=0, head_p=tail_p=0, commit_valid=0, flush=0, alloc_ready=1.
- **In-order retire.** Alloc rd=1,2,3 (tags 0,1,2). CDB tag2=0x0033, then tag0=0x0011, then tag1=0x0022 → commits retire in order (1,0x0011), (2,0x0022), (3,0x0033). Tag 2 does not commit before tags 0 and 1.
- **Full/wrap.** Alloc 8 entries → alloc_ready=0, count=8. Resolve and commit tag 0; alloc the same cycle is refused and accepted the next cycle with alloc_tag=0. Then tail_p=1.
- **Simultaneous alloc and commit.** With count=4, hold alloc_valid and a ready head → count stays 4 while head_p and tail_p each advance by 1.
- **Mispredict.** Alloc branch (tag 0) and then rd=5 (tag 1). CDB tag1=0x00AA, then tag0 with cdb_mispredict=1 → flush pulses one cycle, commit_valid never asserts for rd=5, and afterwards count=0 with the next alloc_tag=0.
- **Correct branch and stray CDB.** A correct branch retires with no commit_valid pulse. A CDB write to a non-busy tag 6 → no state change.
